// File: rtl/regfile_debug_port_pkg.sv
// regfile_debug_port_pkg: shared constants, FSM encodings and op decode for the register file debug port
package regfile_debug_port_pkg;
  localparam int XLEN = 32;
  localparam int REGS = 32;
  localparam int ADDR_W = $clog2(REGS);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    CLEAR = 3'd3,
    RESP  = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2
  } dbg_op_t;
  // clear-all takes precedence over write
  function automatic dbg_op_t decode_op(input logic clear, input logic write);
    return clear ? OP_CLEAR : write ? OP_WRITE : OP_READ;
  endfunction
  function automatic state_t op_state(input dbg_op_t op);
    return op == OP_CLEAR ? CLEAR : op == OP_WRITE ? WRITE : READ;
  endfunction
endpackage

// File: rtl/regfile_debug_port_if.sv
// regfile_debug_port_if: debug transport request/response handshakes
interface regfile_debug_port_if;
  import regfile_debug_port_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic req_clear;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0] req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [XLEN-1:0] rsp_data;
  modport master (
    output req_valid, req_write, req_clear, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_write, req_clear, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/regfile_debug_port.sv
// regfile_debug_port: debug-side initiator driving register file read port 1 and the write port while halted
module regfile_debug_port
  import regfile_debug_port_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic core_halted,
  input  logic core_we,
  regfile_debug_port_if.slave dbg,
  output logic rf_sel,
  output logic [ADDR_W-1:0] rf_a1,
  input  logic [XLEN-1:0] rf_rd1,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0] rf_di3,
  output logic rf_we3
);
  state_t state, next;
  logic [ADDR_W-1:0] addr, cnt;
  logic [XLEN-1:0] data, rsp;
  logic req_fire, wr;
  assign req_fire = dbg.req_valid && dbg.req_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = req_fire ? op_state(decode_op(dbg.req_clear, dbg.req_write)) : IDLE;
      READ:    next = RESP;
      WRITE:   next = core_we ? WRITE : RESP;
      CLEAR:   next = !core_we && cnt == ADDR_W'(REGS - 1) ? RESP : CLEAR;
      RESP:    next = dbg.rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      data <= '0;
      cnt  <= '0;
      rsp  <= '0;
    end else begin
      if (req_fire) begin
        addr <= dbg.req_addr;
        data <= dbg.req_data;
        cnt  <= ADDR_W'(1);
      end
      if (state == READ) rsp <= rf_rd1;
      if (state == WRITE && !core_we) rsp <= '0;
      // core writeback stalls the sweep without losing its place
      if (state == CLEAR && !core_we) begin
        cnt <= cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(REGS - 1)) rsp <= XLEN'(REGS - 1);
      end
    end
  end
  // x0 is architecturally zero, so a debug write to it never touches the port
  always_comb begin
    wr = !core_we && (state == CLEAR || (state == WRITE && addr != '0));
    dbg.req_ready = reset_n && core_halted && state == IDLE;
    dbg.rsp_valid = state == RESP;
    dbg.rsp_data = rsp;
    rf_sel = state == READ;
    rf_a1 = rf_sel ? addr : '0;
    rf_we3 = wr;
    rf_a3 = !wr ? '0 : state == CLEAR ? cnt : addr;
    rf_di3 = wr && state == WRITE ? data : '0;
  end
endmodule

// File: tb/tb_regfile_debug_port.sv
// tb_regfile_debug_port: randomized directed bench against an array model of the register file
module tb_regfile_debug_port;
  import regfile_debug_port_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic core_halted = 1'b1;
  logic core_we = 1'b0;
  logic rf_sel, rf_we3;
  logic [ADDR_W-1:0] rf_a1, rf_a3;
  logic [XLEN-1:0] rf_rd1, rf_di3;
  logic [XLEN-1:0] rf_mem [REGS] = '{default: '0};
  logic [XLEN-1:0] model [REGS] = '{default: '0};
  logic [ADDR_W+XLEN-1:0] wq [$];
  int viol = 0;
  int passed = 0;
  int total = 0;

  regfile_debug_port_if dbg();

  regfile_debug_port dut (
    .clk(clk),
    .reset_n(reset_n),
    .core_halted(core_halted),
    .core_we(core_we),
    .dbg(dbg),
    .rf_sel(rf_sel),
    .rf_a1(rf_a1),
    .rf_rd1(rf_rd1),
    .rf_a3(rf_a3),
    .rf_di3(rf_di3),
    .rf_we3(rf_we3)
  );

  always #5 clk = ~clk;

  assign rf_rd1 = rf_a1 == '0 ? '0 : rf_mem[rf_a1];

  always @(posedge clk) begin
    if (rf_we3) begin
      wq.push_back({rf_a3, rf_di3});
      if (rf_a3 != '0) rf_mem[rf_a3] <= rf_di3;
    end
    if (rf_we3 && core_we) viol++;
    if (rf_we3 && rf_sel) viol++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_req(input logic wr, input logic clr, input logic [ADDR_W-1:0] a,
                        input logic [XLEN-1:0] d, input int stall, input int drop_at,
                        input int hold, output logic [XLEN-1:0] rsp, output int lat);
    int n = 0;
    dbg.req_valid = 1'b1;
    dbg.req_write = wr;
    dbg.req_clear = clr;
    dbg.req_addr = a;
    dbg.req_data = d;
    #1;
    while (!dbg.req_ready && n < 20) begin
      step;
      n++;
    end
    check("accept", 64'(dbg.req_ready), 64'd1);
    step;
    dbg.req_valid = 1'b0;
    lat = 1;
    core_we = stall >= 1;
    #1;
    while (!dbg.rsp_valid && lat < 200) begin
      step;
      lat++;
      core_we = lat <= stall;
      if (lat == drop_at) core_halted = 1'b0;
      #1;
    end
    core_we = 1'b0;
    check("rsp_valid", 64'(dbg.rsp_valid), 64'd1);
    rsp = dbg.rsp_data;
    repeat (hold) begin
      step;
      check("rsp_held", 64'(dbg.rsp_valid), 64'd1);
    end
    dbg.rsp_ready = 1'b1;
    step;
    dbg.rsp_ready = 1'b0;
    #1;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    if (a == '0) check("x0_no_pulse", 64'(wq.size()), 64'd0);
    else begin
      check("pulse_count", 64'(wq.size()), 64'd1);
      if (wq.size() > 0) check("pulse", 64'(wq[0]), 64'({a, d}));
    end
    wq.delete();
  endtask

  task automatic expect_clear(input int upto);
    check("clear_pulses", 64'(wq.size()), 64'(upto));
    for (int i = 1; i <= upto && i <= wq.size(); i++)
      check($sformatf("clear_pulse_%0d", i), 64'(wq[i-1]), 64'({ADDR_W'(i), XLEN'(0)}));
    wq.delete();
  endtask

  task automatic preload;
    logic [XLEN-1:0] r, d;
    int lat;
    for (int i = 1; i < REGS; i++) begin
      d = $urandom | 32'h1;
      do_req(1'b1, 1'b0, ADDR_W'(i), d, 0, 0, 0, r, lat);
      model[i] = d;
    end
    wq.delete();
  endtask

  initial begin
    logic [XLEN-1:0] r, d;
    logic [ADDR_W-1:0] a;
    int lat, busy;
    dbg.req_valid = 1'b1;
    dbg.req_write = 1'b1;
    dbg.req_clear = 1'b0;
    dbg.req_addr = 5'd5;
    dbg.req_data = '1;
    dbg.rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", 64'(dbg.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(dbg.rsp_data), 64'd0);
    check("rst_rf_sel", 64'(rf_sel), 64'd0);
    check("rst_rf_we3", 64'({rf_we3, rf_a1, rf_a3, rf_di3}), 64'd0);
    step;
    reset_n = 1'b1;
    dbg.req_valid = 1'b0;
    dbg.rsp_ready = 1'b0;
    #1;
    check("idle_req_ready", 64'(dbg.req_ready), 64'd1);

    do_req(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 0, 0, $urandom_range(0, 2), r, lat);
    model[5] = 32'hDEADBEEF;
    check("w5_rsp", 64'(r), 64'd0);
    check("w5_lat", 64'(lat), 64'd2);
    expect_write(5'd5, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 5'd5, '0, 0, 0, $urandom_range(0, 2), r, lat);
    check("r5_data", 64'(r), 64'(model[5]));
    check("r5_lat", 64'(lat), 64'd2);
    expect_write(5'd0, '0);

    do_req(1'b1, 1'b0, 5'd0, 32'h1234, 0, 0, 0, r, lat);
    check("w0_rsp", 64'(r), 64'd0);
    expect_write(5'd0, '0);
    do_req(1'b0, 1'b0, 5'd0, '0, 0, 0, 0, r, lat);
    check("r0_data", 64'(r), 64'd0);

    do_req(1'b1, 1'b0, 5'd7, 32'h55, 3, 0, 0, r, lat);
    model[7] = 32'h55;
    check("w7_stall_lat", 64'(lat), 64'd5);
    check("w7_stall_rsp", 64'(r), 64'd0);
    expect_write(5'd7, 32'h55);

    preload;
    for (int k = 0; k < 8; k++) begin
      a = ADDR_W'($urandom_range(1, REGS - 1));
      do_req(1'b0, 1'b0, a, '0, 0, 0, $urandom_range(0, 2), r, lat);
      check($sformatf("rand_read_x%0d", a), 64'(r), 64'(model[a]));
      check("rand_read_lat", 64'(lat), 64'd2);
    end
    for (int k = 0; k < 4; k++) begin
      a = ADDR_W'($urandom_range(0, REGS - 1));
      d = $urandom;
      do_req(1'b1, 1'b0, a, d, $urandom_range(0, 2), 0, 0, r, lat);
      if (a != '0) model[a] = d;
      expect_write(a, d);
    end

    do_req(1'b1, 1'b1, 5'd9, 32'hFFFF, 0, 0, 0, r, lat);
    for (int i = 1; i < REGS; i++) model[i] = '0;
    check("clear_rsp", 64'(r), 64'(REGS - 1));
    check("clear_lat", 64'(lat), 64'(REGS));
    expect_clear(REGS - 1);
    do_req(1'b0, 1'b0, 5'd1, '0, 0, 0, 0, r, lat);
    check("clear_x1", 64'(r), 64'(model[1]));
    do_req(1'b0, 1'b0, 5'd31, '0, 0, 0, 0, r, lat);
    check("clear_x31", 64'(r), 64'(model[31]));

    core_halted = 1'b0;
    dbg.req_valid = 1'b1;
    dbg.req_write = 1'b1;
    dbg.req_addr = 5'd3;
    dbg.req_data = 32'hABCD;
    #1;
    busy = 0;
    repeat (5) begin
      if (dbg.req_ready || rf_sel || rf_we3) busy++;
      step;
    end
    check("unhalted_idle", 64'(busy), 64'd0);
    check("unhalted_no_pulse", 64'(wq.size()), 64'd0);
    dbg.req_valid = 1'b0;
    core_halted = 1'b1;

    preload;
    do_req(1'b0, 1'b1, 5'd0, '0, 2, 6, 0, r, lat);
    for (int i = 1; i < REGS; i++) model[i] = '0;
    core_halted = 1'b1;
    check("drop_clear_rsp", 64'(r), 64'(REGS - 1));
    check("drop_clear_lat", 64'(lat), 64'(REGS + 2));
    expect_clear(REGS - 1);

    preload;
    dbg.req_valid = 1'b1;
    dbg.req_clear = 1'b1;
    #1;
    busy = 0;
    while (!dbg.req_ready && busy < 20) begin
      step;
      busy++;
    end
    step;
    dbg.req_valid = 1'b0;
    dbg.req_clear = 1'b0;
    repeat (10) step;
    reset_n = 1'b0;
    #1;
    check("abort_outputs", 64'({rf_we3, rf_sel, rf_a1, rf_a3, rf_di3}), 64'd0);
    check("abort_handshake", 64'({dbg.req_ready, dbg.rsp_valid, dbg.rsp_data}), 64'd0);
    for (int i = 1; i <= 10; i++) model[i] = '0;
    repeat (3) step;
    reset_n = 1'b1;
    dbg.rsp_ready = 1'b1;
    busy = 0;
    repeat (40) begin
      if (dbg.rsp_valid || rf_we3) busy++;
      step;
    end
    dbg.rsp_ready = 1'b0;
    check("abort_no_rsp", 64'(busy), 64'd0);
    expect_clear(10);
    do_req(1'b0, 1'b0, 5'd20, '0, 0, 0, 0, r, lat);
    check("abort_x20", 64'(r), 64'(model[20]));
    do_req(1'b0, 1'b0, 5'd4, '0, 0, 0, 0, r, lat);
    check("abort_x4", 64'(r), 64'(model[4]));

    check("we3_core_overlap", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
